// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - reaction-time game controller driven by a 2-bit PRBS wait selector
module reaction_timer #(
    parameter int MIN_DELAY  = 500,
    parameter int DELAY_UNIT = 250,
    parameter int TW         = 12
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Tick,
    input  logic [1:0]    Ran,
    input  logic          Start,
    input  logic          Button,
    output logic          Led,
    output logic          Busy,
    output logic          Done,
    output logic          Cheat,
    output logic [TW-1:0] Time
);

    // Delay counter must hold the longest possible wait (Ran = 3).
    localparam int MAX_DELAY = MIN_DELAY + 3 * DELAY_UNIT;
    localparam int CW        = $clog2(MAX_DELAY + 1);

    localparam logic [CW-1:0] DELAY_0 = CW'(MIN_DELAY);
    localparam logic [CW-1:0] DELAY_1 = CW'(MIN_DELAY + DELAY_UNIT);
    localparam logic [CW-1:0] DELAY_2 = CW'(MIN_DELAY + 2 * DELAY_UNIT);
    localparam logic [CW-1:0] DELAY_3 = CW'(MAX_DELAY);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [TW-1:0] TIME_MAX = {TW{1'b1}};
    localparam logic [TW-1:0] TIME_ONE = TW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_ARMED  = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
    localparam logic [2:0] S_CHEAT  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] time_q, time_d;
    logic          led_q, led_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cheat_q, cheat_d;
    logic          start_q, button_q;
    logic          start_edge, button_edge;
    logic [CW-1:0] delay_load;

    assign start_edge  = Start & ~start_q;
    assign button_edge = Button & ~button_q;

    // Wait length selected by the PRBS value sampled on the start edge.
    always_comb begin
        delay_load = DELAY_0;
        case (Ran)
            2'd0:    delay_load = DELAY_0;
            2'd1:    delay_load = DELAY_1;
            2'd2:    delay_load = DELAY_2;
            default: delay_load = DELAY_3;
        endcase
    end

    // Next-state and next-output logic; outputs are computed here so they flop with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        time_d  = time_q;
        led_d   = led_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cheat_d = cheat_q;
        case (state_q)
            S_WAIT: begin
                // An early press beats a coincident final tick.
                if (button_edge) begin
                    state_d = S_CHEAT;
                    cheat_d = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (Tick) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_ARMED;
                        led_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_ARMED: begin
                // A tick coinciding with the press still counts; time never wraps.
                if (Tick && (time_q != TIME_MAX)) begin
                    time_d = time_q + TIME_ONE;
                end
                if (button_edge || (time_q == TIME_MAX)) begin
                    state_d = S_RESULT;
                    done_d  = 1'b1;
                    led_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                // IDLE, RESULT and CHEAT hold their outputs until a new start.
                if (start_edge) begin
                    state_d = S_WAIT;
                    cnt_d   = delay_load;
                    time_d  = '0;
                    done_d  = 1'b0;
                    cheat_d = 1'b0;
                    led_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
        endcase
    end

    // State, counters and registered outputs; edge history resets high to suppress held inputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            time_q   <= '0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cheat_q  <= 1'b0;
            start_q  <= 1'b1;
            button_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            time_q   <= time_d;
            led_q    <= led_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cheat_q  <= cheat_d;
            start_q  <= Start;
            button_q <= Button;
        end
    end

    assign Led   = led_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Cheat = cheat_q;
    assign Time  = time_q;

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - scoreboard bench for reaction_timer
module tb_reaction_timer;

    localparam int MIN_DELAY  = 4;
    localparam int DELAY_UNIT = 2;
    localparam int TW         = 4;

    logic          Clock;
    logic          Reset;
    logic          Tick;
    logic [1:0]    Ran;
    logic          Start;
    logic          Button;
    logic          Led;
    logic          Busy;
    logic          Done;
    logic          Cheat;
    logic [TW-1:0] Time;

    typedef struct {
        int cheat;
        int tm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic done_prev = 1'b0;
    logic led_seen;

    reaction_timer #(
        .MIN_DELAY (MIN_DELAY),
        .DELAY_UNIT(DELAY_UNIT),
        .TW        (TW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Tick  (Tick),
        .Ran   (Ran),
        .Start (Start),
        .Button(Button),
        .Led   (Led),
        .Busy  (Busy),
        .Done  (Done),
        .Cheat (Cheat),
        .Time  (Time)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given Tick level; returns 1 ns after the edge.
    task automatic cyc(input logic t);
        Tick = t;
        @(posedge Clock);
        #1;
    endtask

    task automatic push_exp(input int cheat, input int tm);
        exp_t e;
        e.cheat = cheat;
        e.tm    = tm;
        sb.push_back(e);
    endtask

    // Pulse Start for one cycle with the given Ran and confirm the run has begun.
    task automatic start_run(input logic [1:0] r, input string tag);
        Ran   = r;
        Start = 1'b1;
        cyc(1'b0);
        Start = 1'b0;
        check({tag, "_busy"}, Busy, 1);
        check({tag, "_done_clr"}, Done, 0);
        check({tag, "_time_clr"}, Time, 0);
        check({tag, "_led"}, Led, 0);
    endtask

    // Tick every cycle through the whole wait; Led must rise exactly on the last tick.
    task automatic wait_led(input int d, input string tag);
        for (int i = 1; i <= d; i++) begin
            cyc(1'b1);
            if (i == d - 1) check({tag, "_led_early"}, Led, 0);
        end
        check({tag, "_led_on"}, Led, 1);
    endtask

    // Scoreboard consumer: each rising Done pops the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (Done && !done_prev) begin
                check("sb_pending", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_cheat", Cheat, e.cheat);
                    check("sb_time", Time, e.tm);
                    check("sb_led_off", Led, 0);
                    check("sb_busy_off", Busy, 0);
                end
            end
            done_prev = Done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset  = 1'b1;
        Tick   = 1'b0;
        Ran    = 2'd0;
        Start  = 1'b1;
        Button = 1'b1;

        // Reset with both buttons held, then release while still held.
        repeat (3) @(posedge Clock);
        #1;
        check("rst_led", Led, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_cheat", Cheat, 0);
        check("rst_time", Time, 0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1);
        check("held_start_busy", Busy, 0);
        check("held_start_done", Done, 0);
        Start  = 1'b0;
        Button = 1'b0;
        cyc(1'b0);

        // Ran=2: wait of 8 ticks, press on the 5th armed tick.
        start_run(2'd2, "t2");
        wait_led(8, "t2");
        for (int i = 0; i < 4; i++) cyc(1'b1);
        push_exp(0, 5);
        Button = 1'b1;
        cyc(1'b1);
        check("t2_done", Done, 1);
        check("t2_time", Time, 5);
        Button = 1'b0;
        cyc(1'b0);

        // Ran=0, tick every third cycle, early press after two ticks.
        start_run(2'd0, "t3");
        led_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc((i % 3) == 2);
            if (Led) led_seen = 1'b1;
        end
        push_exp(1, 0);
        Button = 1'b1;
        cyc(1'b0);
        if (Led) led_seen = 1'b1;
        check("t3_cheat", Cheat, 1);
        check("t3_time", Time, 0);
        check("t3_led_never", led_seen, 0);
        Button = 1'b0;
        for (int i = 0; i < 6; i++) cyc((i % 3) == 2);
        check("t3_hold_cheat", Cheat, 1);

        // Ran=1, no press: time saturates and the run ends on its own.
        start_run(2'd1, "t4");
        wait_led(6, "t4");
        push_exp(0, 15);
        for (int i = 0; i < 40 && !Done; i++) cyc(1'b1);
        check("t4_timeout_done", Done, 1);
        check("t4_time_sat", Time, 15);
        check("t4_cheat", Cheat, 0);
        check("t4_led", Led, 0);

        // Start during ARMED is ignored.
        start_run(2'd0, "t5a");
        wait_led(4, "t5a");
        cyc(1'b1);
        cyc(1'b1);
        Start = 1'b1;
        cyc(1'b1);
        Start = 1'b0;
        check("t5_ignore_start_led", Led, 1);
        check("t5_ignore_start_busy", Busy, 1);
        check("t5_ignore_start_done", Done, 0);
        cyc(1'b1);
        push_exp(0, 5);
        Button = 1'b1;
        cyc(1'b1);
        Button = 1'b0;
        cyc(1'b0);
        check("t5_result_time", Time, 5);

        // Restart from RESULT with Ran=3: wait of 10 ticks, then one-tick press.
        start_run(2'd3, "t5b");
        wait_led(10, "t5b");
        push_exp(0, 1);
        Button = 1'b1;
        cyc(1'b1);

        // Button still held from RESULT through WAIT into ARMED gives no result.
        cyc(1'b0);
        start_run(2'd0, "t6");
        check("t6_no_cheat_held", Cheat, 0);
        wait_led(4, "t6");
        cyc(1'b1);
        check("t6_held_no_done", Done, 0);
        Button = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        push_exp(0, 3);
        Button = 1'b1;
        cyc(1'b0);
        check("t6_time", Time, 3);
        Button = 1'b0;
        cyc(1'b0);

        // Reset in the middle of ARMED clears everything at once.
        start_run(2'd0, "t6r");
        wait_led(4, "t6r");
        cyc(1'b1);
        cyc(1'b1);
        Reset = 1'b1;
        #1;
        check("midrst_led", Led, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        check("midrst_time", Time, 0);
        check("midrst_cheat", Cheat, 0);
        cyc(1'b0);
        Reset = 1'b0;
        cyc(1'b0);
        check("post_rst_busy", Busy, 0);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Reaction-time game controller that sits directly downstream of the LFSR PRBS generator and consumes its 2-bit Ran output.
- On a Start press it picks a pseudo-random wait from Ran, then lights the LED.
- It measures Tick periods until the Button press and reports the result, or flags a press made before the LED came on.
- Feeds the display/score logic.

Parameters:
- MIN_DELAY, 500, minimum wait in Tick periods; must be >= 1.
- DELAY_UNIT, 250, extra wait in Tick periods per unit of Ran.
- TW, 12, width of the Time result in bits.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous reset, active-high.
- Tick  input  1  single-cycle timebase enable, e.g. 1 ms strobe, synchronous to Clock.
- Ran  input  2  pseudo-random value from the LFSR generator.
- Start  input  1  start button, synchronous level.
- Button  input  1  reaction button, synchronous level.
- Led  output  1  high while the player must react.
- Busy  output  1  high while a run is in progress (WAIT or ARMED).
- Done  output  1  high once a run has finished, held until the next start.
- Cheat  output  1  high when the run ended by an early press.
- Time  output  TW  measured reaction time in Tick periods.

Behaviour:
- Edge detection:
  - start_q and button_q register the previous Start and Button.
  - start_edge = Start & ~start_q; button_edge = Button & ~button_q.
  - Only edges act, never levels.
- Reset:
  - State goes to IDLE.
  - Led, Busy, Done, Cheat and Time are 0; the delay counter is 0.
  - start_q and button_q reset to 1, so an input held high through reset release produces no edge.
- States: IDLE, WAIT, ARMED, RESULT, CHEAT.
- IDLE, RESULT and CHEAT (Busy=0):
  - On start_edge, load delay counter with D = MIN_DELAY + Ran*DELAY_UNIT.
  - Ran is sampled on the same clock edge that leaves the state.
  - Clear Done, Cheat and Time; next state WAIT.
  - RESULT and CHEAT hold Time, Done and Cheat until a start_edge.
  - button_edge is ignored.
- WAIT (Busy=1, Led=0):
  - Counter decrements on each Tick.
  - Tick while counter==1 moves to ARMED on the next edge, so ARMED begins after exactly D Ticks.
  - button_edge in WAIT moves to CHEAT: Cheat=1, Done=1, Time stays 0. This has priority over a simultaneous final Tick.
  - start_edge is ignored.
- ARMED (Busy=1, Led=1):
  - Time increments by 1 on each Tick.
  - button_edge moves to RESULT: Done=1, Led=0.
  - A Tick in the same cycle as button_edge is counted.
  - Saturation: when Time reaches 2^TW-1, move to RESULT on the next edge with Time held at max, Done=1, Cheat=0 (timeout).
  - start_edge is ignored.
- Outputs are registered: Led, Busy, Done and Cheat change on the clock edge of the state transition.
- Width rule: the delay counter is wide enough for MIN_DELAY+3*DELAY_UNIT.
- Reset asserted mid-run aborts immediately to the reset values.

Test Plan:
(Override MIN_DELAY=4, DELAY_UNIT=2, TW=4 unless stated.)
1. Assert Reset with Start=Button=1, then release -> all outputs 0, state IDLE, no run starts while Start stays high.
2. Tick=1 every cycle, Ran=2, Start pulse -> Busy=1 the next cycle, Led rises after 8 WAIT cycles. Button rises after 5 Ticks in ARMED -> Time=5, Done=1, Led=0, Busy=0, Cheat=0.
3. Ran=0, Tick every 3rd cycle, Button press after 2 Ticks in WAIT -> Cheat=1, Done=1, Time=0, Led never high.
4. Ran=1, no Button press -> Time saturates at 15, Done=1, Cheat=0, Led=0.
5. Start pulse during ARMED -> ignored, run continues. From RESULT, Start with Ran=3 -> Done/Time cleared, Led rises after 10 Ticks.
6. Button held high from WAIT into ARMED -> no result. Release and re-press after 3 Ticks -> Time=3. Reset asserted mid-ARMED -> all outputs 0 immediately.
